memory_issue_scheduler: RTL and testbench

//  Sits between instruction decode and the memory block (data BRAM + FMA read/write buffers).

---
 rtl/memory_issue_scheduler.sv | 148 ++++++++++++++
 tb/tb_memory_issue_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_issue_scheduler.sv
// Memory-class instruction issue scheduler: small FIFO, one issue per cycle, BRAM write->read
// spacing and single outstanding WRITEB read. Optional STALL_COUNTER_EN adds stall_count_out.
module memory_issue_scheduler #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int FIFO_DEPTH        = 4,
   parameter int BRAM_LATENCY      = 2,
   parameter int RD_TIMEOUT        = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
   input  logic                         instr_valid_in,
   output logic                         instr_ready_out,
   output logic [INSTRUCTION_WIDTH-1:0] mem_instr_out,
   output logic                         mem_instr_valid_out,
   input  logic                         abc_valid_in,
   output logic                         busy_out,
   output logic                         drop_out,
   output logic                         timeout_out,
`ifdef STALL_COUNTER_EN
   output logic [15:0]                  stall_count_out,
`endif
   output logic                         state_dbg_out
);

   localparam int IW  = INSTRUCTION_WIDTH;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam int WRW = (BRAM_LATENCY > 0) ? $clog2(BRAM_LATENCY + 1) : 1;
   localparam int RDW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

   localparam logic [3:0] OP_SMA    = 4'b0110;
   localparam logic [3:0] OP_LOADI  = 4'b0111;
   localparam logic [3:0] OP_LOADB  = 4'b1000;
   localparam logic [3:0] OP_WRITEB = 4'b1001;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } state_t;

   // Handshake: an instruction is taken on a rising edge where instr_valid_in && instr_ready_out;
   // mem_instr_valid_out is a single-cycle strobe with no back-pressure from the memory block.

   logic [IW-1:0]  fifo_q [FIFO_DEPTH];
   logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   state_t         state_q;
   logic [WRW-1:0] wr_cnt_q;
   logic [RDW-1:0] rd_cnt_q;

   logic          full, empty, accept, in_is_mem, push, issue;
   logic [3:0]    in_op, head_op;
   logic [IW-1:0] head;

   always_comb begin
      full      = (count_q == CW'(FIFO_DEPTH));
      empty     = (count_q == '0);
      in_op     = instr_in[IW-1 -: 4];
      in_is_mem = (in_op == OP_SMA) || (in_op == OP_LOADI) ||
                  (in_op == OP_LOADB) || (in_op == OP_WRITEB);
      accept    = instr_valid_in && !full;
      push      = accept && in_is_mem;
      head      = fifo_q[rd_ptr_q];
      head_op   = head[IW-1 -: 4];
      // Only WRITEB must wait for the BRAM write spacing; other memory ops go straight out.
      issue     = (state_q == IDLE) && !empty &&
                  ((head_op != OP_WRITEB) || (wr_cnt_q == '0));
      count_d   = count_q + CW'(push) - CW'(issue);
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= instr_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q             <= IDLE;
         rd_ptr_q            <= '0;
         wr_ptr_q            <= '0;
         count_q             <= '0;
         wr_cnt_q            <= '0;
         rd_cnt_q            <= '0;
         mem_instr_out       <= '0;
         mem_instr_valid_out <= 1'b0;
         drop_out            <= 1'b0;
         timeout_out         <= 1'b0;
      end else begin
         count_q             <= count_d;
         mem_instr_valid_out <= issue;
         drop_out            <= accept && !in_is_mem;
         timeout_out         <= 1'b0;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (issue) begin
            mem_instr_out <= head;
            rd_ptr_q      <= rd_ptr_q + 1'b1;
         end
         if (issue && ((head_op == OP_LOADI) || (head_op == OP_LOADB))) begin
            wr_cnt_q <= WRW'(BRAM_LATENCY - 1);
         end else if (wr_cnt_q != '0) begin
            wr_cnt_q <= wr_cnt_q - 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (issue && (head_op == OP_WRITEB)) begin
                  state_q  <= WAIT_RD;
                  rd_cnt_q <= '0;
               end
            end
            WAIT_RD: begin
               // abc_valid_in wins over an expiry landing on the same edge.
               if (abc_valid_in) begin
                  state_q <= IDLE;
               end else if (rd_cnt_q == RDW'(RD_TIMEOUT - 1)) begin
                  timeout_out <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready_out = !full;
   assign busy_out        = !empty || (state_q != IDLE);
   assign state_dbg_out   = (state_q == WAIT_RD);

`ifdef STALL_COUNTER_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stall_q <= '0;
      end else if (!empty && !issue && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count_out = stall_q;
`endif

endmodule

// File: tb/tb_memory_issue_scheduler.sv
// Bench for memory_issue_scheduler: directed scenarios then random traffic, all outputs compared
// every cycle against a queue/timestamp model of the scheduling rules.
module tb_memory_issue_scheduler;

   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int BL    = 2;
   localparam int RT    = 8;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic [IW-1:0] instr_in = '0;
   logic          instr_valid_in = 1'b0;
   logic          abc_valid_in = 1'b0;
   logic          instr_ready_out;
   logic [IW-1:0] mem_instr_out;
   logic          mem_instr_valid_out;
   logic          busy_out;
   logic          drop_out;
   logic          timeout_out;
   logic          state_dbg_out;
`ifdef STALL_COUNTER_EN
   logic [15:0]   stall_count_out;
`endif

   always #5 clk_in = ~clk_in;

   memory_issue_scheduler #(
      .INSTRUCTION_WIDTH(IW),
      .FIFO_DEPTH(DEPTH),
      .BRAM_LATENCY(BL),
      .RD_TIMEOUT(RT)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .instr_in(instr_in),
      .instr_valid_in(instr_valid_in),
      .instr_ready_out(instr_ready_out),
      .mem_instr_out(mem_instr_out),
      .mem_instr_valid_out(mem_instr_valid_out),
      .abc_valid_in(abc_valid_in),
      .busy_out(busy_out),
      .drop_out(drop_out),
      .timeout_out(timeout_out),
`ifdef STALL_COUNTER_EN
      .stall_count_out(stall_count_out),
`endif
      .state_dbg_out(state_dbg_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Model state: pending instructions, edge of the last LOADI/LOADB issue, outstanding WRITEB.
   logic [31:0] mq[$];
   bit          m_wait = 1'b0;
   int          m_wstart = 0;
   int          m_lastload = -1000;
   int          n = 0;
   bit          started = 1'b0;
   logic [31:0] e_instr = '0;
   bit          e_valid = 1'b0;
   bit          e_drop = 1'b0;
   bit          e_to = 1'b0;
   int          e_stall = 0;

   task automatic model_step();
      logic [31:0] head;
      bit          issue;
      bit          hs;
      int          sz;
      head  = '0;
      issue = 1'b0;
      if (rst_in) begin
         started    = 1'b1;
         mq.delete();
         m_wait     = 1'b0;
         m_lastload = -1000;
         e_instr    = '0;
         e_valid    = 1'b0;
         e_drop     = 1'b0;
         e_to       = 1'b0;
         e_stall    = 0;
      end else begin
         sz     = mq.size();
         hs     = instr_valid_in && (sz < DEPTH);
         e_drop = 1'b0;
         e_to   = 1'b0;
         if (m_wait) begin
            if (abc_valid_in) begin
               m_wait = 1'b0;
            end else if (n - m_wstart == RT) begin
               m_wait = 1'b0;
               e_to   = 1'b1;
            end
         end else if (sz > 0) begin
            head = mq[0];
            if (head[31:28] != 4'h9 || (n - m_lastload) >= BL) issue = 1'b1;
         end
         if (issue) begin
            void'(mq.pop_front());
            e_instr = head;
            if (head[31:28] == 4'h7 || head[31:28] == 4'h8) m_lastload = n;
            if (head[31:28] == 4'h9) begin
               m_wait   = 1'b1;
               m_wstart = n;
            end
         end
         e_valid = issue;
         if (hs) begin
            if (instr_in[31:28] inside {4'h6, 4'h7, 4'h8, 4'h9}) mq.push_back(instr_in);
            else e_drop = 1'b1;
         end
         if (sz > 0 && !issue && e_stall < 65535) e_stall++;
      end
      n++;
   endtask

   task automatic compare();
      chk("ready", 32'(instr_ready_out), 32'(mq.size() < DEPTH));
      chk("valid", 32'(mem_instr_valid_out), 32'(e_valid));
      chk("instr", mem_instr_out, e_instr);
      chk("busy", 32'(busy_out), 32'(mq.size() > 0 || m_wait));
      chk("drop", 32'(drop_out), 32'(e_drop));
      chk("timeout", 32'(timeout_out), 32'(e_to));
      chk("state", 32'(state_dbg_out), 32'(m_wait));
`ifdef STALL_COUNTER_EN
      chk("stall", 32'(stall_count_out), 32'(e_stall));
`endif
   endtask

   always @(posedge clk_in) begin
      model_step();
      #1;
      if (started) compare();
   end

   task automatic cyc(input bit v, input logic [31:0] ins, input bit abc, input bit r);
      instr_valid_in = v;
      instr_in       = ins;
      abc_valid_in   = abc;
      rst_in         = r;
      @(negedge clk_in);
   endtask

   initial begin
      int k;
      logic [31:0] w;

      // Reset values and single SMA latency
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 1);
      chk("rst_ready", 32'(instr_ready_out), 32'd1);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_valid", 32'(mem_instr_valid_out), 32'd0);
      chk("rst_instr", mem_instr_out, 32'd0);
      chk("rst_drop", 32'(drop_out), 32'd0);
      chk("rst_timeout", 32'(timeout_out), 32'd0);
      cyc(1, 32'h6001_7800, 0, 0);
      cyc(0, '0, 0, 0);
      chk("sma_valid", 32'(mem_instr_valid_out), 32'd1);
      chk("sma_instr", mem_instr_out, 32'h6001_7800);

      // LOADI then WRITEB: write spacing
      cyc(1, 32'h7088_8800, 0, 0);
      cyc(1, 32'h9000_0000, 0, 0);
      chk("loadi_instr", mem_instr_out, 32'h7088_8800);
      cyc(0, '0, 0, 0);
      chk("writeb_held", 32'(mem_instr_valid_out), 32'd0);
      cyc(0, '0, 0, 0);
      chk("writeb_valid", 32'(mem_instr_valid_out), 32'd1);
      chk("writeb_instr", mem_instr_out, 32'h9000_0000);

      // Read wait released by abc_valid_in three cycles after issue
      cyc(1, 32'h6000_0001, 0, 0);
      chk("gap1", 32'(mem_instr_valid_out), 32'd0);
      cyc(0, '0, 0, 0);
      chk("gap2", 32'(mem_instr_valid_out), 32'd0);
      cyc(0, '0, 1, 0);
      chk("gap3", 32'(mem_instr_valid_out), 32'd0);
      cyc(0, '0, 0, 0);
      chk("after_abc_instr", mem_instr_out, 32'h6000_0001);
      chk("after_abc_valid", 32'(mem_instr_valid_out), 32'd1);

      // Read wait expiry
      cyc(1, 32'h9000_0004, 0, 0);
      cyc(1, 32'h6000_0002, 0, 0);
      chk("wb2_instr", mem_instr_out, 32'h9000_0004);
      k = 21;
      for (int i = 1; i <= 20; i++) begin
         cyc(0, '0, 0, 0);
         if (timeout_out) begin
            k = i;
            break;
         end
      end
      chk("timeout_latency", 32'(k), 32'd8);
      cyc(0, '0, 0, 0);
      chk("resume_instr", mem_instr_out, 32'h6000_0002);

      // Fill FIFO while waiting; 5th push refused
      cyc(1, 32'h9000_0008, 0, 0);
      cyc(0, '0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("fill_ready", 32'(instr_ready_out), (i < 4) ? 32'd1 : 32'd0);
         cyc(1, 32'h6000_0010 + 32'(i), 0, 0);
      end
      cyc(0, '0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 0, 0);
         chk("drain_instr", mem_instr_out, 32'h6000_0010 + 32'(i));
      end
      cyc(1, 32'h2000_0012, 0, 0);
      chk("xor_drop", 32'(drop_out), 32'd1);
      cyc(0, '0, 0, 0);
      chk("xor_drop_end", 32'(drop_out), 32'd0);
      chk("xor_not_issued", 32'(mem_instr_valid_out), 32'd0);

      // Reset in the middle of a read wait with work queued
      cyc(1, 32'h9000_0020, 0, 0);
      cyc(1, 32'h6000_0030, 0, 0);
      cyc(1, 32'h6000_0031, 0, 0);
      cyc(1, 32'h6000_0032, 0, 0);
      chk("pre_rst_wait", 32'(state_dbg_out), 32'd1);
      cyc(0, '0, 0, 1);
      chk("mid_rst_busy", 32'(busy_out), 32'd0);
      chk("mid_rst_ready", 32'(instr_ready_out), 32'd1);
`ifdef STALL_COUNTER_EN
      chk("mid_rst_stall", 32'(stall_count_out), 32'd0);
`endif
      for (int i = 0; i < 10; i++) begin
         cyc(0, '0, 0, 0);
         chk("post_rst_quiet", 32'(mem_instr_valid_out), 32'd0);
      end

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         w = $urandom;
         if ($urandom_range(0, 99) < 80) w[31:28] = 4'(6 + $urandom_range(0, 3));
         cyc($urandom_range(0, 99) < 60, w, $urandom_range(0, 99) < 12,
             $urandom_range(0, 999) < 4);
      end
      cyc(0, '0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
